// File: rtl/lsu_pipe_if.sv
// lsu_pipe_if: request/response handshake bundle between the core memory
// stage (master) and the load/store unit (slave).
interface lsu_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic                  req_we_i;
  logic [2:0]            req_dtype_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_dtype_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_dtype_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/lsu_pipe.sv
// lsu_pipe: load/store unit with one outstanding request, a byte-lane RAM
// with one-cycle read latency, split handling of word-crossing accesses and
// a bank of NUM_GPIO word registers mapped at GPIO_BASE.
// Build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned accesses are
// rejected with an error instead of being split over two RAM words.
module lsu_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH*DATA_WIDTH/8),
  parameter int NUM_GPIO   = 2,
  parameter int GPIO_BASE  = 32'hEF0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  lsu_pipe_if.slave                      bus,
  output logic [NUM_GPIO*DATA_WIDTH-1:0] gpio_o
);
  localparam int LANES  = DATA_WIDTH / 8;
  localparam int OFF_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SZ_W   = $clog2(LANES) + 1;
  localparam int WIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] GPIO_LO = (ADDR_WIDTH+1)'(GPIO_BASE);
  localparam logic [ADDR_WIDTH:0] GPIO_HI = (ADDR_WIDTH+1)'(GPIO_BASE + NUM_GPIO*LANES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SECOND = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Access size in bytes for a dtype code; 0 marks an illegal code.
  function automatic logic [SZ_W-1:0] f_size(input logic [2:0] dt);
    case (dt)
      3'd0, 3'd3: f_size = SZ_W'(1);
      3'd1, 3'd4: f_size = SZ_W'(2);
      3'd2:       f_size = SZ_W'(LANES);
      default:    f_size = SZ_W'(0);
    endcase
  endfunction

  state_t                         r_state;
  state_t                         w_next;
  logic [ADDR_WIDTH-1:0]          r_addr;
  logic                           r_we;
  logic [2:0]                     r_dtype;
  logic [DATA_WIDTH-1:0]          r_wdata;
  logic [DATA_WIDTH-1:0]          r_first;
  logic                           r_split;
  logic                           r_rsp_valid;
  logic                           r_err;
  logic                           r_load_ok;
  logic                           r_from_gpio;
  logic [DATA_WIDTH-1:0]          r_gpio_q;
  logic [NUM_GPIO*DATA_WIDTH-1:0] r_gpio;

  logic [DATA_WIDTH-1:0]          r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]          r_ram_q;

  logic [OFF_W-1:0]               w_off;
  logic [SZ_W-1:0]                w_size;
  logic                           w_illegal;
  logic                           w_cross;
  logic                           w_gpio_hit;
  logic                           w_gpio_ok;
  logic [ADDR_WIDTH-1:0]          w_gpio_idx;
  logic [31:0]                    w_gpio_k;
  logic                           w_err;
  logic                           w_split;
  logic [WIDX_W-1:0]              w_widx0;
  logic [WIDX_W-1:0]              w_widx1;
  logic [LANES-1:0]               w_be_base;
  logic [2*LANES-1:0]             w_be2;
  logic [2*DATA_WIDTH-1:0]        w_wdata2;
  logic                           w_ram_en;
  logic [LANES-1:0]               w_ram_we;
  logic [WIDX_W-1:0]              w_ram_widx;
  logic [DATA_WIDTH-1:0]          w_ram_wdata;
  logic [2*DATA_WIDTH-1:0]        w_pair;
  logic [2*DATA_WIDTH-1:0]        w_shift;
  logic [DATA_WIDTH-1:0]          w_raw;
  logic [DATA_WIDTH-1:0]          w_ext;

  // Decode of the captured request: lane offset, size, window hit, errors.
  assign w_off      = OFF_W'(r_addr % ADDR_WIDTH'(LANES));
  assign w_size     = f_size(r_dtype);
  assign w_illegal  = (w_size == SZ_W'(0));
  assign w_cross    = (int'(w_off) + int'(w_size)) > LANES;
  assign w_gpio_hit = ({1'b0, r_addr} >= GPIO_LO) && ({1'b0, r_addr} < GPIO_HI);
  assign w_gpio_ok  = (r_dtype == 3'd2) && (w_off == OFF_W'(0));
  assign w_gpio_idx = (r_addr - ADDR_WIDTH'(GPIO_BASE)) / ADDR_WIDTH'(LANES);
  assign w_gpio_k   = 32'(w_gpio_idx);

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misalign;

  // An access is misaligned when its address is not a multiple of its size.
  always_comb begin
    case (r_dtype)
      3'd1, 3'd4: w_misalign = r_addr[0];
      3'd2:       w_misalign = (w_off != OFF_W'(0));
      default:    w_misalign = 1'b0;
    endcase
  end

  assign w_err = w_illegal || (w_gpio_hit && !w_gpio_ok) || w_misalign;
`else
  assign w_err = w_illegal || (w_gpio_hit && !w_gpio_ok);
`endif

  assign w_split = !w_err && !w_gpio_hit && w_cross;

  // First word index and its successor, wrapping past the last RAM word.
  assign w_widx0 = WIDX_W'(r_addr / ADDR_WIDTH'(LANES));
  assign w_widx1 = (w_widx0 == WIDX_W'(DEPTH - 1)) ? WIDX_W'(0) : (w_widx0 + WIDX_W'(1));

  // Contiguous lane mask of the access size, starting at lane 0.
  always_comb begin
    w_be_base = '0;
    for (int l = 0; l < LANES; l++) begin
      if (l < int'(w_size)) begin
        w_be_base[l] = 1'b1;
      end else begin
        w_be_base[l] = 1'b0;
      end
    end
  end

  // Rotate enables and store data onto a two-word lane window.
  assign w_be2    = {{LANES{1'b0}}, w_be_base} << w_off;
  assign w_wdata2 = {{DATA_WIDTH{1'b0}}, r_wdata} << {w_off, 3'b000};

  // RAM port control: first word in ACCESS, remaining lanes in SECOND.
  always_comb begin
    w_ram_en    = 1'b0;
    w_ram_we    = '0;
    w_ram_widx  = w_widx0;
    w_ram_wdata = w_wdata2[DATA_WIDTH-1:0];
    case (r_state)
      ACCESS: begin
        if (!w_err && !w_gpio_hit) begin
          w_ram_en = reset_n;
          if (r_we) begin
            w_ram_we = w_be2[LANES-1:0];
          end else begin
            w_ram_we = '0;
          end
        end else begin
          w_ram_en = 1'b0;
        end
      end
      SECOND: begin
        w_ram_en    = reset_n;
        w_ram_widx  = w_widx1;
        w_ram_wdata = w_wdata2[2*DATA_WIDTH-1:DATA_WIDTH];
        if (r_we) begin
          w_ram_we = w_be2[2*LANES-1:LANES];
        end else begin
          w_ram_we = '0;
        end
      end
      default: begin
        w_ram_en = 1'b0;
      end
    endcase
  end

  // Byte-lane synchronous RAM, one-cycle read latency, contents never reset.
  always_ff @(posedge clk) begin
    if (w_ram_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (w_ram_we[l]) begin
          r_mem[w_ram_widx][l*8 +: 8] <= w_ram_wdata[l*8 +: 8];
        end
      end
      r_ram_q <= r_mem[w_ram_widx];
    end
  end

  // Next-state logic for the single-outstanding request sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req_valid_i) begin
          w_next = ACCESS;
        end else begin
          w_next = IDLE;
        end
      end
      ACCESS: begin
        if (w_split) begin
          w_next = SECOND;
        end else begin
          w_next = RESP;
        end
      end
      SECOND: begin
        w_next = RESP;
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          w_next = IDLE;
        end else begin
          w_next = RESP;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register, request capture, GPIO bank and response registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_dtype     <= 3'd0;
      r_wdata     <= '0;
      r_first     <= '0;
      r_split     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_load_ok   <= 1'b0;
      r_from_gpio <= 1'b0;
      r_gpio_q    <= '0;
      r_gpio      <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (bus.req_valid_i) begin
            r_addr  <= bus.req_addr_i;
            r_we    <= bus.req_we_i;
            r_dtype <= bus.req_dtype_i;
            r_wdata <= bus.req_wdata_i;
          end
        end
        ACCESS: begin
          r_split <= w_split;
          if (!w_split) begin
            r_rsp_valid <= 1'b1;
            r_err       <= w_err;
            r_load_ok   <= !r_we && !w_err;
            r_from_gpio <= w_gpio_hit;
          end
          if (w_gpio_hit && !w_err) begin
            if (r_we) begin
              r_gpio[w_gpio_k*DATA_WIDTH +: DATA_WIDTH] <= r_wdata;
            end else begin
              r_gpio_q <= r_gpio[w_gpio_k*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
        SECOND: begin
          r_first     <= r_ram_q;
          r_rsp_valid <= 1'b1;
          r_err       <= 1'b0;
          r_load_ok   <= !r_we;
          r_from_gpio <= 1'b0;
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_load_ok   <= 1'b0;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Byte-merge the RAM words and extend the loaded value per dtype.
  always_comb begin
    if (r_split) begin
      w_pair = {r_ram_q, r_first};
    end else begin
      w_pair = {{DATA_WIDTH{1'b0}}, r_ram_q};
    end
    w_shift = w_pair >> {w_off, 3'b000};
    w_raw   = w_shift[DATA_WIDTH-1:0];
    case (r_dtype)
      3'd0:    w_ext = {{(DATA_WIDTH-8){w_raw[7]}}, w_raw[7:0]};
      3'd1:    w_ext = {{(DATA_WIDTH-16){w_raw[15]}}, w_raw[15:0]};
      3'd2:    w_ext = w_raw;
      3'd3:    w_ext = {{(DATA_WIDTH-8){1'b0}}, w_raw[7:0]};
      3'd4:    w_ext = {{(DATA_WIDTH-16){1'b0}}, w_raw[15:0]};
      default: w_ext = '0;
    endcase
  end

  // Response data comes only from held registers, so it stays stable in RESP.
  always_comb begin
    if (r_rsp_valid && r_load_ok) begin
      if (r_from_gpio) begin
        bus.rsp_rdata_o = r_gpio_q;
      end else begin
        bus.rsp_rdata_o = w_ext;
      end
    end else begin
      bus.rsp_rdata_o = '0;
    end
  end

  assign bus.req_ready_o = (r_state == IDLE);
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_err_o   = r_err;
  assign gpio_o          = r_gpio;
endmodule
